// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM states, owner encoding and
// default bus widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } arb_state_e;

  typedef enum logic {
    OwnIf = 1'b0,
    OwnDm = 1'b1
  } owner_e;

  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 8;
  localparam int unsigned CntW     = 3;

endpackage

// File: rtl/mem_wait_counter.sv
// Latency counter for the memory port: counts BUSY cycles and flags when the configured read
// latency has elapsed.
module mem_wait_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == CntW'(MEM_LAT));

  // Saturates at MEM_LAT so the 3-bit count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !done_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch (IF) and data (DM) requesters.
// Define ARB_RR_EN for round-robin on contention; otherwise DM has fixed priority over IF.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_dm,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              cnt_clr, cnt_en, cnt_done;
  logic              pick_dm;

`ifdef ARB_RR_EN
  // owner_q only changes on a grant, so it doubles as the last-owner flag.
  assign pick_dm = dm_req && (!if_req || (owner_q == OwnIf));
`else
  assign pick_dm = dm_req;
`endif

  mem_wait_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_wait_counter (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .done_o (cnt_done)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    mem_en_d   = mem_en_q;
    mem_we_d   = 1'b0;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    cnt_clr    = 1'b1;
    cnt_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (if_req || dm_req) begin
          state_d  = StBusy;
          owner_d  = pick_dm ? OwnDm : OwnIf;
          addr_d   = pick_dm ? dm_addr : if_addr;
          mem_en_d = 1'b1;
          // Write strobe only in the first BUSY cycle so each access writes once.
          mem_we_d = pick_dm && dm_we;
          if (pick_dm) begin
            wdata_d = dm_wdata;
          end
        end
      end
      StBusy: begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
        if (cnt_done) begin
          state_d  = StResp;
          mem_en_d = 1'b0;
          if (owner_q == OwnDm) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= OwnIf;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign grant_dm  = (owner_q == OwnDm);
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3) with behavioural memories,
// checked against a transaction-level model of grant order, ack timing and memory contents.
module tb_mem_port_arbiter;

`ifdef ARB_RR_EN
  localparam bit RrBuild = 1'b1;
`else
  localparam bit RrBuild = 1'b0;
`endif

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       if_req    [2];
  logic [7:0] if_addr   [2];
  logic       if_ack    [2];
  logic [7:0] if_rdata  [2];
  logic       dm_req    [2];
  logic       dm_we     [2];
  logic [7:0] dm_addr   [2];
  logic [7:0] dm_wdata  [2];
  logic       dm_ack    [2];
  logic [7:0] dm_rdata  [2];
  logic       mem_en    [2];
  logic       mem_we    [2];
  logic [7:0] mem_addr  [2];
  logic [7:0] mem_wdata [2];
  logic [7:0] mem_rdata [2];
  logic       grant_dm  [2];
  logic       busy      [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W  (8),
      .DATA_W  (8),
      .MEM_LAT ((g == 0) ? 1 : 3)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_ack    (if_ack[g]),
      .if_rdata  (if_rdata[g]),
      .dm_req    (dm_req[g]),
      .dm_we     (dm_we[g]),
      .dm_addr   (dm_addr[g]),
      .dm_wdata  (dm_wdata[g]),
      .dm_ack    (dm_ack[g]),
      .dm_rdata  (dm_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .grant_dm  (grant_dm[g]),
      .busy      (busy[g])
    );
  end

  function automatic logic [7:0] init_val(input int a);
    case (a)
      0:       return 8'h01;
      1:       return 8'h04;
      2:       return 8'h10;
      3:       return 8'h80;
      default: return 8'(a * 7 + 3);
    endcase
  endfunction

  // Behavioural memories: registered read with a MEM_LAT-deep output pipeline.
  logic [7:0] mem  [2][256];
  logic [7:0] pipe [2][3];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int a = 0; a < 256; a++) mem[d][a] <= init_val(a);
      end else if (mem_en[d] && mem_we[d]) begin
        mem[d][mem_addr[d]] <= mem_wdata[d];
      end
      pipe[d][0] <= mem[d][mem_addr[d]];
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
    end
  end
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  // Reference model state
  logic [7:0] ref_mem [2][256];
  bit         last_dm [2];
  bit         exp_gdm [2];
  txn_t       if_q[$];
  txn_t       dm_q[$];
  int         vectors = 0;
  int         miscompares = 0;

  function automatic txn_t mk(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    txn_t t;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 256; a++) ref_mem[d][a] = init_val(a);
      last_dm[d] = 1'b0;
      exp_gdm[d] = 1'b0;
    end
  endtask

  task automatic drive(input int d, input bit ion, input txn_t ir, input bit don, input txn_t dr);
    if_req[d]   = ion;
    if_addr[d]  = ir.addr;
    dm_req[d]   = don;
    dm_we[d]    = dr.we;
    dm_addr[d]  = dr.addr;
    dm_wdata[d] = dr.wdata;
  endtask

  task automatic check_reset(input int d);
    chk($sformatf("rst_if_ack%0d", d), if_ack[d], 0);
    chk($sformatf("rst_dm_ack%0d", d), dm_ack[d], 0);
    chk($sformatf("rst_mem_en%0d", d), mem_en[d], 0);
    chk($sformatf("rst_mem_we%0d", d), mem_we[d], 0);
    chk($sformatf("rst_busy%0d", d), busy[d], 0);
    chk($sformatf("rst_mem_addr%0d", d), mem_addr[d], 0);
    chk($sformatf("rst_mem_wdata%0d", d), mem_wdata[d], 0);
    chk($sformatf("rst_if_rdata%0d", d), if_rdata[d], 0);
    chk($sformatf("rst_dm_rdata%0d", d), dm_rdata[d], 0);
    chk($sformatf("rst_grant_dm%0d", d), grant_dm[d], 0);
  endtask

  // Serves the queued transactions on instance d; each requester re-presents immediately after
  // its ack until its queue is empty. Returns the cycle of the last ack of each requester.
  task automatic run(input int d, output int if_cyc, output int dm_cyc);
    int         lat, idle_c, gnt_c, ack_c;
    bit         own_dm, if_on, dm_on, pick, done;
    txn_t       ifr, dmr, cur;
    logic [7:0] exp_data;
    lat = (d == 0) ? 1 : 3;
    idle_c = 0; gnt_c = -100; ack_c = -100;
    own_dm = 1'b0; if_on = 1'b0; dm_on = 1'b0; done = 1'b0;
    ifr = '0; dmr = '0; cur = '0; exp_data = '0;
    if_cyc = -1; dm_cyc = -1;
    @(negedge clk);
    if (if_q.size() > 0) begin ifr = if_q.pop_front(); if_on = 1'b1; end
    if (dm_q.size() > 0) begin dmr = dm_q.pop_front(); dm_on = 1'b1; end
    drive(d, if_on, ifr, dm_on, dmr);
    for (int k = 0; k < 300 && !done; k++) begin
      if (k > 0) @(negedge clk);
      if (k == gnt_c + 1) exp_gdm[d] = own_dm;
      chk($sformatf("busy%0d", d), busy[d], (k > gnt_c) && (k <= ack_c));
      chk($sformatf("mem_en%0d", d), mem_en[d], (k > gnt_c) && (k <= gnt_c + 1 + lat));
      chk($sformatf("mem_we%0d", d), mem_we[d], (k == gnt_c + 1) && cur.we);
      chk($sformatf("if_ack%0d", d), if_ack[d], (k == ack_c) && !own_dm);
      chk($sformatf("dm_ack%0d", d), dm_ack[d], (k == ack_c) && own_dm);
      chk($sformatf("grant_dm%0d", d), grant_dm[d], exp_gdm[d]);
      if (k == gnt_c + 1) begin
        chk($sformatf("mem_addr%0d", d), mem_addr[d], cur.addr);
        if (cur.we) chk($sformatf("mem_wdata%0d", d), mem_wdata[d], cur.wdata);
      end
      if (k == ack_c) begin
        if (own_dm) begin
          dm_cyc = k;
          if (!cur.we) chk($sformatf("dm_rdata%0d", d), dm_rdata[d], exp_data);
          if (dm_q.size() > 0) dmr = dm_q.pop_front();
          else dm_on = 1'b0;
        end else begin
          if_cyc = k;
          chk($sformatf("if_rdata%0d", d), if_rdata[d], exp_data);
          if (if_q.size() > 0) ifr = if_q.pop_front();
          else if_on = 1'b0;
        end
        drive(d, if_on, ifr, dm_on, dmr);
      end
      if (k == idle_c) begin
        if (if_on || dm_on) begin
          if (if_on && dm_on) pick = RrBuild ? !last_dm[d] : 1'b1;
          else pick = dm_on;
          last_dm[d] = pick;
          own_dm = pick;
          cur = pick ? dmr : mk(1'b0, ifr.addr, 8'h00);
          gnt_c = k;
          ack_c = k + 2 + lat;
          idle_c = k + 3 + lat;
          exp_data = ref_mem[d][cur.addr];
          if (cur.we) ref_mem[d][cur.addr] = cur.wdata;
        end else begin
          idle_c = k + 1;
        end
      end
      if (!if_on && !dm_on && k >= ack_c) done = 1'b1;
    end
    if (!done) begin
      miscompares++;
      $error("FAIL run_timeout%0d: observed no completion expected all acks", d);
    end
  endtask

  initial begin
    #2000000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ic, dc, n_if, n_dm, d;
    for (int i = 0; i < 2; i++) drive(i, 1'b0, '0, 1'b0, '0);
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst = 1'b0;

    // IF read of address 0
    if_q.push_back(mk(1'b0, 8'd0, 8'h00));
    run(0, ic, dc);
    chk("t1_if_ack_cycle", ic, 3);
    chk("t1_if_rdata", if_rdata[0], 8'h01);

    // DM write then IF read of the same address
    dm_q.push_back(mk(1'b1, 8'd4, 8'h20));
    run(0, ic, dc);
    chk("t2_dm_ack_cycle", dc, 3);
    if_q.push_back(mk(1'b0, 8'd4, 8'h00));
    run(0, ic, dc);
    chk("t2_if_rdata", if_rdata[0], 8'h20);

    // Simultaneous requests
    if_q.push_back(mk(1'b0, 8'd1, 8'h00));
    dm_q.push_back(mk(1'b0, 8'd2, 8'h00));
    run(0, ic, dc);
    chk("t3_dm_ack_cycle", dc, 3);
    chk("t3_if_ack_cycle", ic, 7);
    chk("t3_dm_rdata", dm_rdata[0], 8'h10);
    chk("t3_if_rdata", if_rdata[0], 8'h04);

    // Both held for four accesses
    for (int i = 0; i < 2; i++) begin
      if_q.push_back(mk(1'b0, 8'(10 + i), 8'h00));
      dm_q.push_back(mk(1'b0, 8'(20 + i), 8'h00));
    end
    run(0, ic, dc);
    chk("t4_if_last_ack", ic, 15);
    chk("t4_dm_last_ack", dc, RrBuild ? 11 : 7);

    // MEM_LAT = 3
    if_q.push_back(mk(1'b0, 8'd3, 8'h00));
    run(1, ic, dc);
    chk("t5_if_ack_cycle", ic, 5);
    chk("t5_if_rdata", if_rdata[1], 8'h80);

    // Reset in the second BUSY cycle
    @(negedge clk);
    drive(0, 1'b1, mk(1'b0, 8'd5, 8'h00), 1'b0, '0);
    @(negedge clk);
    chk("t6_busy_c1", busy[0], 1);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("t6_no_ack", if_ack[0], 0);
    if_q.push_back(mk(1'b0, 8'd5, 8'h00));
    run(0, ic, dc);
    chk("t6_if_ack_cycle", ic, 3);
    chk("t6_if_rdata", if_rdata[0], init_val(5));

    // Random traffic
    for (int it = 0; it < 30; it++) begin
      d = int'($urandom_range(0, 1));
      n_if = int'($urandom_range(0, 3));
      n_dm = int'($urandom_range(0, 3));
      for (int j = 0; j < n_if; j++) if_q.push_back(mk(1'b0, 8'($urandom), 8'h00));
      for (int j = 0; j < n_dm; j++) begin
        dm_q.push_back(mk(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom)));
      end
      run(d, ic, dc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
